i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//  I2C target (responder) with 8-bit register pointer and auto-increment; answers the
//  initiator sequences issued by the on-board I2C command master (write: addr+W, reg, data...;
//  read: addr+W, reg, Sr, addr+R, data...). Exposes a single-cycle register-bus strobe
//  interface to a local register file. Lets the gateware be configured/inspected over I2C.
// PARAMETERS
//  DEV_ADDR    7'h50  7-bit target address matched after START / repeated START
//  FILTER_LEN  3      clk cycles SCL/SDA must be stable before a level change is accepted
// PORTS
//  clk        in   1  system clock (>= 20x SCL rate)
//  rst_n      in   1  asynchronous active-low reset
//  scl_i      in   1  SCL pad input (never driven; no clock stretching)
//  sda_i      in   1  SDA pad input
//  sda_o      out  1  SDA output value, constant 0
//  sda_t      out  1  SDA tristate: 1 = released, 0 = drive low
//  reg_addr   out  8  register pointer
//  reg_wdata  out  8  write data, valid with reg_wr
//  reg_wr     out  1  one-clk write strobe
//  reg_rd     out  1  one-clk read strobe; reg_rdata must be valid on the following clk
//  reg_rdata  in   8  read data
//  busy       out  1  high from START to STOP (any address)
// BEHAVIOUR
//  - Reset: sda_t=1, sda_o=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, state IDLE.
//  - Inputs: 2-FF synchroniser then FILTER_LEN stability filter; filtered levels feed edge detect.
//  - START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both take precedence over
//    any state; START (incl. repeated) -> ADDR, bit count 0; STOP -> IDLE, sda_t=1, busy=0.
//  - Data bits sampled on filtered SCL rise, MSB first; sda_t changes only on filtered SCL fall.
//  - States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//  - ADDR: 8 bits; [7:1]==DEV_ADDR -> ADDR_ACK (drive low for 9th clock); else IGNORE (released
//    until STOP/START). R/W=0 -> REG; R/W=1 -> RDATA.
//  - REG: byte loads reg_addr, ACK, -> WDATA. WDATA: byte -> reg_wdata, reg_wr pulses 1 clk on the
//    SCL rise of bit 8 (pointer value pre-increment), ACK, then reg_addr += 1 on ACK-clock fall.
//  - RDATA: reg_rd pulses 1 clk on the SCL fall that ends ADDR_ACK or RDATA_ACK; next clk reg_rdata
//    latched to shift reg, bit 7 driven (sda_t = bit) before SCL rises; reg_addr += 1 after latch.
//  - RDATA_ACK: sda_t=1; sampled ACK(0) -> RDATA; NACK(1) -> IGNORE.
//  - reg_addr increments modulo 256 (8'hFF -> 8'h00). Pointer persists across transactions
//    (plain read without REG phase reads from current pointer).
//  - reg_wr and reg_rd never assert together; never more than one per byte.
//  - STOP/START mid-byte: partial byte discarded, no strobe issued.
//  - Async reset mid-transfer: SDA released within the reset assertion, no strobe emitted.
// STRUCTURE
//  - Package i2c_pkg: state enum i2c_tgt_state_t, I2C_ACK/I2C_NACK constants.
//  - Sub-module i2c_pin_filter (sync + stability filter + scl_rise/scl_fall/start/stop pulses),
//    instantiated once; FSM, shift register and pointer live in i2c_target.
// TESTING
//  - Write 0x50+W, 0x17, 0x04, STOP -> ACK x3; reg_wr once with reg_addr=0x17, reg_wdata=0x04.
//  - Burst write at reg 0xFE: 0xAA,0xBB,0xCC -> writes at 0xFE,0xFF,0x00 (wrap), all ACKed.
//  - Write 0x50+W,0x10; Sr; 0x50+R; read 2 bytes ACK then NACK, model returns addr^0x5A ->
//    SDA bytes 0x4A,0x4B; reg_rd twice; SDA released after NACK; busy low after STOP.
//  - Address 0x51+W -> SDA never driven low, no strobes, busy high until STOP.
//  - STOP after 4 bits of WDATA -> no reg_wr; next transaction ACKs normally.
//  - 1-clk glitches on SCL/SDA (FILTER_LEN=3) and rst_n pulsed mid-read -> no false START/bit;
//    after reset sda_t=1, reg_addr=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_pin_filter.sv
// Synchronises and debounces SCL/SDA, then derives bus events from the clean levels.
module i2c_pin_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_f_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    scl_sync_q, sda_sync_q;
    logic          scl_f_q, sda_f_q, scl_p_q, sda_p_q;
    logic [CW-1:0] scl_cnt_q, sda_cnt_q;

    // A new level is only accepted after FILTER_LEN consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_p_q    <= scl_f_q;
            sda_p_q    <= sda_f_q;

            if (scl_sync_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CW'(FILTER_LEN - 1)) begin
                scl_f_q   <= scl_sync_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end

            if (sda_sync_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CW'(FILTER_LEN - 1)) begin
                sda_f_q   <= sda_sync_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 1'b1;
            end
        end
    end

    assign sda_f_o    = sda_f_q;
    assign scl_rise_o = scl_f_q & ~scl_p_q;
    assign scl_fall_o = ~scl_f_q & scl_p_q;
    assign start_o    = sda_p_q & ~sda_f_q & scl_f_q & scl_p_q;
    assign stop_o     = ~sda_p_q & sda_f_q & scl_f_q & scl_p_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an auto-incrementing 8-bit register pointer and a strobe-based register bus.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           scl_i,
    input  logic           sda_i,
    output logic           sda_o,
    output logic           sda_t,
    output logic [7:0]     reg_addr,
    output logic [7:0]     reg_wdata,
    output logic           reg_wr,
    output logic           reg_rd,
    input  logic [7:0]     reg_rdata,
    output logic           busy,
    output i2c_tgt_state_t state_o
);

    logic sda_f, scl_rise, scl_fall, start_evt, stop_evt;

    i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_f_o    (sda_f),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_evt),
        .stop_o     (stop_evt)
    );

    i2c_tgt_state_t state_q;
    logic [3:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic [7:0]     reg_addr_q, reg_wdata_q;
    logic           sda_t_q, reg_wr_q, reg_rd_q, busy_q, rw_q;
    logic [7:0]     shift_in;

    assign shift_in = {shift_q[6:0], sda_f};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            sda_t_q     <= 1'b1;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            if (stop_evt) begin
                state_q   <= ST_IDLE;
                sda_t_q   <= 1'b1;
                busy_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else if (start_evt) begin
                state_q   <= ST_ADDR;
                sda_t_q   <= 1'b1;
                busy_q    <= 1'b1;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (scl_rise) begin
                            shift_q   <= shift_in;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                case (state_q)
                                    ST_ADDR: begin
                                        if (shift_in[7:1] == DEV_ADDR) begin
                                            state_q <= ST_ADDR_ACK;
                                            rw_q    <= shift_in[0];
                                        end else begin
                                            state_q <= ST_IGNORE;
                                        end
                                    end
                                    ST_REG: begin
                                        reg_addr_q <= shift_in;
                                        state_q    <= ST_REG_ACK;
                                    end
                                    default: begin
                                        reg_wdata_q <= shift_in;
                                        reg_wr_q    <= 1'b1;
                                        state_q     <= ST_WDATA_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    // bit_cnt 0: the fall ending bit 8 starts the ACK; 1: the fall ending the 9th clock.
                    ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd0) begin
                                sda_t_q   <= I2C_ACK;
                                bit_cnt_q <= 4'd1;
                            end else begin
                                sda_t_q   <= 1'b1;
                                bit_cnt_q <= '0;
                                case (state_q)
                                    ST_ADDR_ACK: begin
                                        if (rw_q) begin
                                            state_q  <= ST_RDATA;
                                            reg_rd_q <= 1'b1;
                                        end else begin
                                            state_q <= ST_REG;
                                        end
                                    end
                                    ST_REG_ACK: state_q <= ST_WDATA;
                                    default: begin
                                        state_q    <= ST_WDATA;
                                        reg_addr_q <= reg_addr_q + 8'd1;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (reg_rd_q) begin
                            shift_q    <= reg_rdata;
                            sda_t_q    <= reg_rdata[7];
                            reg_addr_q <= reg_addr_q + 8'd1;
                            bit_cnt_q  <= '0;
                        end else if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_q   <= ST_RDATA_ACK;
                                sda_t_q   <= 1'b1;
                                bit_cnt_q <= '0;
                            end else begin
                                sda_t_q <= shift_q[6];
                                shift_q <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            shift_q[0] <= sda_f;
                            bit_cnt_q  <= 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd1) begin
                            bit_cnt_q <= '0;
                            if (shift_q[0] == I2C_ACK) begin
                                state_q  <= ST_RDATA;
                                reg_rd_q <= 1'b1;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_o     = 1'b0;
    assign sda_t     = sda_t_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: an I2C initiator model drives the bus; a register model answers reads.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           scl_drv = 1'b1;
    logic           sda_drv = 1'b1;
    logic           sda_o, sda_t, reg_wr, reg_rd, busy;
    logic [7:0]     reg_addr, reg_wdata, reg_rdata;
    i2c_tgt_state_t state_o;
    wire            sda_line = sda_drv & (sda_t | sda_o);

    int          total = 0;
    int          bad = 0;
    int          rd_cnt = 0;
    int          both_cnt = 0;
    logic        low_seen = 1'b0;
    logic [15:0] wr_log[$];
    logic [15:0] exp_q[$];

    i2c_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_drv),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    assign reg_rdata = reg_addr ^ 8'h5A;

    always @(negedge clk) begin
        if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
        if (reg_rd) rd_cnt++;
        if (reg_wr && reg_rd) both_cnt++;
        if (!sda_t) low_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        exp_q.delete();
        rd_cnt = 0;
        low_seen = 1'b0;
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_rstart();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_drv = b; tick(Q);
        scl_drv = 1'b1; tick(2 * Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    // Same bit, but with 1-clk SCL and SDA glitches that must be filtered out.
    task automatic put_bit_glitchy(input logic b);
        sda_drv = b; tick(4);
        scl_drv = 1'b1; tick(1);
        scl_drv = 1'b0; tick(5);
        scl_drv = 1'b1; tick(Q);
        sda_drv = ~b; tick(1);
        sda_drv = b; tick(Q - 1);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        b = sda_line; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(ack);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        total++; if (sda_t !== 1'b1) begin bad++; $display("FAIL reset_sda_t got=%b exp=1", sda_t); end
        total++; if (sda_o !== 1'b0) begin bad++; $display("FAIL reset_sda_o got=%b exp=0", sda_o); end
        total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL reset_reg_addr got=%h exp=00", reg_addr); end
        total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_reg_wdata got=%h exp=00", reg_wdata); end
        total++; if ({reg_wr, reg_rd, busy} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b exp=000", {reg_wr, reg_rd, busy}); end
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_o, ST_IDLE); end
        rst_n = 1'b1;
        tick(Q);
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        clear_logs();
        bus_start();
        put_byte(8'hA0, a0);
        put_byte(8'h17, a1);
        put_byte(8'h04, a2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy got=%b exp=1", busy); end
        bus_stop();
        tick(Q);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL write_acks got=%b exp=000", {a0, a1, a2}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
        total++; if (reg_addr !== 8'h18) begin bad++; $display("FAIL write_ptr got=%h exp=18", reg_addr); end
        total++; if (rd_cnt !== 0) begin bad++; $display("FAIL write_rd_cnt got=%0d exp=0", rd_cnt); end
        exp_q.push_back(16'h1704);
        total++;
        if (wr_log.size() != exp_q.size()) begin
            bad++; $display("FAIL write_wr_count got=%0d exp=%0d", wr_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL write_wr[%0d] got=%h exp=%h", i, wr_log[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_burst_wrap();
        logic [4:0] acks;
        clear_logs();
        bus_start();
        put_byte(8'hA0, acks[0]);
        put_byte(8'hFE, acks[1]);
        put_byte(8'hAA, acks[2]);
        put_byte(8'hBB, acks[3]);
        put_byte(8'hCC, acks[4]);
        bus_stop();
        tick(Q);
        total++; if (acks !== 5'b00000) begin bad++; $display("FAIL burst_acks got=%b exp=00000", acks); end
        total++; if (reg_addr !== 8'h01) begin bad++; $display("FAIL burst_ptr got=%h exp=01", reg_addr); end
        exp_q.push_back(16'hFEAA);
        exp_q.push_back(16'hFFBB);
        exp_q.push_back(16'h00CC);
        total++;
        if (wr_log.size() != exp_q.size()) begin
            bad++; $display("FAIL burst_wr_count got=%0d exp=%0d", wr_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL burst_wr[%0d] got=%h exp=%h", i, wr_log[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        clear_logs();
        bus_start();
        put_byte(8'hA0, a0);
        put_byte(8'h10, a1);
        bus_rstart();
        put_byte(8'hA1, a2);
        get_byte(d0, I2C_ACK);
        get_byte(d1, I2C_NACK);
        total++; if (sda_t !== 1'b1) begin bad++; $display("FAIL read_release got=%b exp=1", sda_t); end
        bus_stop();
        tick(Q);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL read_acks got=%b exp=000", {a0, a1, a2}); end
        total++; if (d0 !== 8'h4A) begin bad++; $display("FAIL read_byte0 got=%h exp=4a", d0); end
        total++; if (d1 !== 8'h4B) begin bad++; $display("FAIL read_byte1 got=%h exp=4b", d1); end
        total++; if (rd_cnt !== 2) begin bad++; $display("FAIL read_rd_cnt got=%0d exp=2", rd_cnt); end
        total++; if (wr_log.size() != 0) begin bad++; $display("FAIL read_wr_cnt got=%0d exp=0", wr_log.size()); end
        total++; if (reg_addr !== 8'h12) begin bad++; $display("FAIL read_ptr got=%h exp=12", reg_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        clear_logs();
        bus_start();
        put_byte(8'hA2, a0);
        put_byte(8'h33, a1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrong_busy got=%b exp=1", busy); end
        bus_stop();
        tick(Q);
        total++; if ({a0, a1} !== 2'b11) begin bad++; $display("FAIL wrong_acks got=%b exp=11", {a0, a1}); end
        total++; if (low_seen !== 1'b0) begin bad++; $display("FAIL wrong_sda_low got=%b exp=0", low_seen); end
        total++; if (wr_log.size() + rd_cnt != 0) begin bad++; $display("FAIL wrong_strobes got=%0d exp=0", wr_log.size() + rd_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrong_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic test_partial_byte();
        logic a0, a1, a2, a3, a4;
        clear_logs();
        bus_start();
        put_byte(8'hA0, a0);
        put_byte(8'h20, a1);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        bus_stop();
        tick(Q);
        total++; if (wr_log.size() != 0) begin bad++; $display("FAIL partial_wr_cnt got=%0d exp=0", wr_log.size()); end
        bus_start();
        put_byte(8'hA0, a2);
        put_byte(8'h21, a3);
        put_byte(8'h99, a4);
        bus_stop();
        tick(Q);
        total++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin bad++; $display("FAIL partial_acks got=%b exp=00000", {a0, a1, a2, a3, a4}); end
        exp_q.push_back(16'h2199);
        total++;
        if (wr_log.size() != exp_q.size()) begin
            bad++; $display("FAIL partial_next_count got=%0d exp=%0d", wr_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL partial_next[%0d] got=%h exp=%h", i, wr_log[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_glitch();
        logic a0, a1, a2;
        clear_logs();
        scl_drv = 1'b0; tick(1); scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(1); sda_drv = 1'b1; tick(Q);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle_busy got=%b exp=0", busy); end
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL glitch_idle_state got=%0d exp=%0d", state_o, ST_IDLE); end
        bus_start();
        put_byte(8'hA0, a0);
        put_byte(8'h30, a1);
        for (int i = 7; i >= 0; i--) put_bit_glitchy(((8'h55 >> i) & 8'h01) != 8'h00);
        get_bit(a2);
        bus_stop();
        tick(Q);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL glitch_acks got=%b exp=000", {a0, a1, a2}); end
        exp_q.push_back(16'h3055);
        total++;
        if (wr_log.size() != exp_q.size()) begin
            bad++; $display("FAIL glitch_wr_count got=%0d exp=%0d", wr_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL glitch_wr[%0d] got=%h exp=%h", i, wr_log[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2, a3, a4, a5, b;
        clear_logs();
        bus_start();
        put_byte(8'hA0, a0);
        put_byte(8'h40, a1);
        bus_rstart();
        put_byte(8'hA1, a2);
        get_bit(b);
        get_bit(b);
        // 0x40 ^ 0x5A = 0x1A, so bit 5 (a zero) is on the line now.
        total++; if (sda_t !== 1'b0) begin bad++; $display("FAIL rstmid_driving got=%b exp=0", sda_t); end
        total++; if (rd_cnt !== 1) begin bad++; $display("FAIL rstmid_rd_before got=%0d exp=1", rd_cnt); end
        rst_n = 1'b0;
        tick(2);
        total++; if (sda_t !== 1'b1) begin bad++; $display("FAIL rstmid_sda_t got=%b exp=1", sda_t); end
        total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL rstmid_ptr got=%h exp=00", reg_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        scl_drv = 1'b1; tick(2);
        sda_drv = 1'b1; tick(Q);
        rst_n = 1'b1;
        tick(Q);
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL rstmid_state got=%0d exp=%0d", state_o, ST_IDLE); end
        total++; if (rd_cnt !== 1 || wr_log.size() != 0) begin bad++; $display("FAIL rstmid_strobes got=rd%0d/wr%0d exp=rd1/wr0", rd_cnt, wr_log.size()); end
        bus_start();
        put_byte(8'hA0, a3);
        put_byte(8'h05, a4);
        put_byte(8'h66, a5);
        bus_stop();
        tick(Q);
        total++; if ({a3, a4, a5} !== 3'b000) begin bad++; $display("FAIL rstmid_after_acks got=%b exp=000", {a3, a4, a5}); end
        exp_q.push_back(16'h0566);
        total++;
        if (wr_log.size() != exp_q.size()) begin
            bad++; $display("FAIL rstmid_wr_count got=%0d exp=%0d", wr_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_wr[%0d] got=%h exp=%h", i, wr_log[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_read();
        test_wrong_addr();
        test_partial_byte();
        test_glitch();
        test_reset_mid_read();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL wr_rd_overlap got=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
